// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared op codes, latency defaults and state type for the multiply/divide unit
//
// Purpose: MDU op-code encoding used by the decoder and the unit, default
//          latencies for mult/div, and the two-state FSM type.
// Ports:   none (package).

package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTLO  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MFLO  = 3'd6,
    MDU_MFHI  = 3'd7
  } mdu_op_e;

  localparam int MDU_MULT_CYC = 5;
  localparam int MDU_DIV_CYC  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - execute-stage multiply/divide unit with HI/LO and busy countdown
//
// Purpose: computes mult/multu/div/divu results at the start edge, holds them
//          in pending registers for a fixed latency, then commits them to
//          HI/LO. Serves mthi/mtlo/mfhi/mflo and flags Busy for stalls.
// Ports:
//   clk       in   1   rising-edge clock
//   reset     in   1   asynchronous, active-high
//   MDUOp     in   3   op code (mdu_op_e)
//   MDUStart  in   1   start mult/multu/div/divu this cycle
//   A         in   32  rs operand
//   B         in   32  rt operand
//   MDUOut    out  32  HI on mfhi, LO on mflo, else 0
//   Busy      out  1   operation in flight
//   HI        out  32  architectural HI
//   LO        out  32  architectural LO

module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYC,
  parameter int DIV_CYCLES  = MDU_DIV_CYC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDUOp,
  input  logic        MDUStart,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] MDUOut,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] div_b;
  logic        [31:0] quot_s, rem_s, quot_u, rem_u;
  logic               b_zero;

  // Arithmetic is evaluated every cycle; only the start edge uses it.
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign b_zero = (B == 32'd0);
  // Substitute a harmless divisor so the dividers never see zero; the
  // divide-by-zero case keeps HI/LO instead of using these results.
  assign div_b  = b_zero ? 32'd1 : B;
  assign quot_s = $signed(A) / $signed(div_b);
  assign rem_s  = $signed(A) % $signed(div_b);
  assign quot_u = A / div_b;
  assign rem_u  = A % div_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (MDUStart) begin
          state_d   = ST_RUN;
          cnt_d     = CNT_W'(MULT_CYCLES);
          pend_hi_d = hi_q;
          pend_lo_d = lo_q;
          case (MDUOp)
            MDU_MULT: begin
              pend_hi_d = prod_s[63:32];
              pend_lo_d = prod_s[31:0];
            end
            MDU_MULTU: begin
              pend_hi_d = prod_u[63:32];
              pend_lo_d = prod_u[31:0];
            end
            MDU_DIV: begin
              cnt_d = CNT_W'(DIV_CYCLES);
              if (!b_zero) begin
                pend_hi_d = rem_s;
                pend_lo_d = quot_s;
              end
            end
            MDU_DIVU: begin
              cnt_d = CNT_W'(DIV_CYCLES);
              if (!b_zero) begin
                pend_hi_d = rem_u;
                pend_lo_d = quot_u;
              end
            end
            default: ;
          endcase
        end else if (MDUOp == MDU_MTHI) begin
          hi_d = A;
        end else if (MDUOp == MDU_MTLO) begin
          lo_d = A;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign Busy   = (state_q == ST_RUN);
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign MDUOut = (MDUOp == MDU_MFHI) ? hi_q :
                  (MDUOp == MDU_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed table-driven bench for mult_div_unit

module tb_mult_div_unit;

  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3;
  localparam logic [2:0] OP_MTLO = 3'd4, OP_MTHI = 3'd5, OP_MFLO = 3'd6, OP_MFHI = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  mdu_op = OP_MFHI;
  logic        mdu_start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] mdu_out;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  mult_div_unit dut (
    .clk     (clk),
    .reset   (reset),
    .MDUOp   (mdu_op),
    .MDUStart(mdu_start),
    .A       (a),
    .B       (b),
    .MDUOut  (mdu_out),
    .Busy    (busy),
    .HI      (hi),
    .LO      (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start for one cycle, then count Busy cycles with a bound.
  task automatic run_op(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                        output int cyc);
    mdu_op = op; a = va; b = vb; mdu_start = 1'b1;
    tick();
    mdu_start = 1'b0; mdu_op = OP_MFHI; a = 32'hFFFF_FFFF; b = 32'd0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask

  initial begin
    int cyc;

    vecs[0] = '{"mult_neg3x7",   OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
    vecs[1] = '{"multu_max_x2",  OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{"div_neg7_2",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{"divu_100_7",    OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        10};
    vecs[4] = '{"div_7_neg2",    OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
    vecs[5] = '{"mult_2p16sq",   OP_MULT,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};
    vecs[6] = '{"multu_2p31sq",  OP_MULTU, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[7] = '{"mult_neg1sq",   OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 5};

    // Reset state
    repeat (2) tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_mdu_out", mdu_out, 32'd0);
    reset = 1'b0;
    tick();

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].va, vecs[i].vb, cyc);
      check({vecs[i].name, "_cycles"}, 32'(cyc), 32'(vecs[i].exp_cyc));
      check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
      mdu_op = OP_MFLO; #1;
      check({vecs[i].name, "_mflo"}, mdu_out, vecs[i].exp_lo);
      mdu_op = OP_MFHI; #1;
      check({vecs[i].name, "_mfhi"}, mdu_out, vecs[i].exp_hi);
      tick();
    end

    // Non-mf op codes read as zero
    mdu_op = OP_MULT; #1;
    check("mdu_out_nonmf", mdu_out, 32'd0);
    mdu_op = OP_MFHI;

    // divu by zero keeps preset HI/LO
    mdu_op = OP_MTHI; a = 32'h11; tick();
    mdu_op = OP_MTLO; a = 32'h22; tick();
    mdu_op = OP_MFHI;
    check("preset_hi", hi, 32'h11);
    check("preset_lo", lo, 32'h22);
    run_op(OP_DIVU, 32'd7, 32'd0, cyc);
    check("divu0_cycles", 32'(cyc), 32'd10);
    check("divu0_hi", hi, 32'h11);
    check("divu0_lo", lo, 32'h22);
    tick();

    // mthi and a second start while busy are ignored
    mdu_op = OP_MULT; a = 32'd3; b = 32'd4; mdu_start = 1'b1;
    tick();
    mdu_start = 1'b0; mdu_op = OP_MTHI; a = 32'h5;
    tick();
    mdu_op = OP_DIV; a = 32'd100; b = 32'd3; mdu_start = 1'b1;
    tick();
    mdu_start = 1'b0; mdu_op = OP_MFHI; a = 32'd0; b = 32'd0; #1;
    check("busy_read_old_hi", mdu_out, 32'h11);
    cyc = 2;
    while (busy && cyc < 100) begin
      cyc++;
      tick();
    end
    check("ignore_cycles", 32'(cyc), 32'd5);
    check("ignore_hi", hi, 32'd0);
    check("ignore_lo", lo, 32'd12);
    tick();
    check("ignore_no_restart", {31'd0, busy}, 32'd0);

    // Async reset mid-divide aborts the operation
    mdu_op = OP_DIV; a = 32'd100; b = 32'd3; mdu_start = 1'b1;
    tick();
    mdu_start = 1'b0; mdu_op = OP_MFHI;
    repeat (2) tick();
    check("div_busy_before_reset", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1; #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_lo", lo, 32'd0);
    tick();
    reset = 1'b0;
    repeat (15) tick();
    check("abort_no_commit_lo", lo, 32'd0);
    check("abort_no_commit_hi", hi, 32'd0);
    check("abort_busy_after", {31'd0, busy}, 32'd0);

    // mtlo then mflo; NOP leaves state alone
    mdu_op = OP_MTLO; a = 32'hDEAD;
    tick();
    mdu_op = OP_MFLO; a = 32'h0; #1;
    check("mtlo_mflo", mdu_out, 32'h0000_DEAD);
    mdu_op = OP_MFHI; a = 32'hCAFE_F00D; b = 32'h1234;
    repeat (4) tick();
    check("nop_hi", hi, 32'd0);
    check("nop_lo", lo, 32'h0000_DEAD);
    check("nop_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
